// File: rtl/inst_arb_pkg.sv
// Shared definitions for the instruction-fetch arbiter: FSM encoding, block geometry
// and the block-align helper.
package inst_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int BLOCK_BYTES_DEF = 32;
  localparam int BLOCK_OFF_W     = $clog2(BLOCK_BYTES_DEF);
  localparam int BLOCK_W         = 256;

  // Clears the low off_w bits so the address points at the start of its block.
  function automatic logic [63:0] block_align(input logic [63:0] addr, input int off_w);
    logic [63:0] mask;
    mask = ~((64'd1 << off_w) - 64'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/inst_arb_watchdog.sv
// WAIT-state watchdog for inst_fetch_arbiter; only built with INST_ARB_TIMEOUT_EN.
// Counts WAIT cycles since the last ISSUE and flags the cycle the limit is reached.
`ifdef INST_ARB_TIMEOUT_EN
module inst_arb_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expire
);

  logic [3:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // The count holds the number of earlier WAIT cycles, so this fires on the TIMEOUT-th one.
  assign o_expire = i_inc && (r_cnt == 4'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/inst_fetch_arbiter.sv
// Shares the 8-word instruction memory between demand-miss and next-line prefetch.
// Optional WAIT watchdog with mem_read retry and timeout_seen port: INST_ARB_TIMEOUT_EN.
module inst_fetch_arbiter
  import inst_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_BYTES = 32,
  parameter int TIMEOUT     = 15
) (
  input  logic               clk,
  input  logic               start,
  input  logic               dmd_req,
  input  logic [ADDR_W-1:0]  dmd_addr,
  output logic               dmd_ack,
  input  logic               prf_req,
  input  logic [ADDR_W-1:0]  prf_addr,
  output logic               prf_ack,
  output logic               mem_read,
  output logic [ADDR_W-1:0]  mem_pc,
  input  logic               mem_valid,
  input  logic [BLOCK_W-1:0] mem_block,
  output logic               resp_valid,
  output logic               resp_to_dmd,
  output logic               resp_to_prf,
  output logic [ADDR_W-1:0]  resp_addr,
  output logic [BLOCK_W-1:0] resp_block,
`ifdef INST_ARB_TIMEOUT_EN
  output logic               timeout_seen,
`endif
  output logic               busy
);

  localparam int OFF_W = $clog2(BLOCK_BYTES);

  if (((BLOCK_BYTES & (BLOCK_BYTES - 1)) != 0) || (TIMEOUT < 2) || (TIMEOUT > 15)) begin : g_param_check
    $error("inst_fetch_arbiter: BLOCK_BYTES must be a power of two and TIMEOUT within 2..15");
  end

  logic [1:0]         r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_own_dmd;
  logic               r_own_prf;
  logic               r_merge_ack;
  logic [BLOCK_W-1:0] r_block;

  logic [ADDR_W-1:0]  w_dmd_al;
  logic [ADDR_W-1:0]  w_prf_al;
  logic               w_merge;
  logic               w_expire;
  logic               w_first_issue;

  assign w_dmd_al = ADDR_W'(block_align(64'(dmd_addr), OFF_W));
  assign w_prf_al = ADDR_W'(block_align(64'(prf_addr), OFF_W));

  // A demand hitting the block already in flight rides on that read instead of queueing.
  assign w_merge = (r_state == ST_WAIT) && dmd_req && !r_own_dmd && (w_dmd_al == r_addr);

`ifdef INST_ARB_TIMEOUT_EN
  logic r_retry;
  logic r_timeout_seen;

  inst_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (clk),
    .i_rst    (start),
    .i_clear  (r_state == ST_ISSUE),
    .i_inc    (r_state == ST_WAIT),
    .o_expire (w_expire)
  );

  // A retried ISSUE re-pulses mem_read but must not repeat the owner acks.
  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      r_retry        <= 1'b0;
      r_timeout_seen <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_retry <= 1'b0;
    end else if ((r_state == ST_WAIT) && !mem_valid && w_expire) begin
      r_retry        <= 1'b1;
      r_timeout_seen <= 1'b1;
    end
  end

  assign w_first_issue = !r_retry;
  assign timeout_seen  = r_timeout_seen;
`else
  assign w_expire      = 1'b0;
  assign w_first_issue = 1'b1;
`endif

  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_own_dmd   <= 1'b0;
      r_own_prf   <= 1'b0;
      r_merge_ack <= 1'b0;
      r_block     <= '0;
    end else begin
      r_merge_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (dmd_req) begin
            r_addr    <= w_dmd_al;
            r_own_dmd <= 1'b1;
            r_own_prf <= prf_req && (w_prf_al == w_dmd_al);
            r_state   <= ST_ISSUE;
          end else if (prf_req) begin
            r_addr    <= w_prf_al;
            r_own_dmd <= 1'b0;
            r_own_prf <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_merge) begin
            r_own_dmd   <= 1'b1;
            r_merge_ack <= 1'b1;
          end
          if (mem_valid) begin
            r_block <= mem_block;
            r_state <= ST_RESP;
          end else if (w_expire) begin
            r_state <= ST_ISSUE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_read    = (r_state == ST_ISSUE);
  assign mem_pc      = r_addr;
  assign dmd_ack     = (mem_read && w_first_issue && r_own_dmd) || r_merge_ack;
  assign prf_ack     = mem_read && w_first_issue && r_own_prf;
  assign resp_valid  = (r_state == ST_RESP);
  assign resp_to_dmd = resp_valid && r_own_dmd;
  assign resp_to_prf = resp_valid && r_own_prf;
  assign resp_addr   = resp_valid ? r_addr : '0;
  assign resp_block  = r_block;
  assign busy        = (r_state != ST_IDLE);

endmodule
